// File: rtl/at_cmd_host_pkg.sv
// Shared constants and types for the AT-command initiator: line terminators,
// expected reply strings, command ids and FSM state encodings.
package at_cmd_host_pkg;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    localparam int unsigned OK_LEN    = 4;
    localparam int unsigned ERROR_LEN = 7;
    localparam logic [OK_LEN*8-1:0]    OK_RESPONSE    = {"OK", CR, LF};
    localparam logic [ERROR_LEN*8-1:0] ERROR_RESPONSE = {"ERROR", CR, LF};

    localparam logic [3:0] CMD_AT         = 4'd0;
    localparam logic [3:0] CMD_MODE_UART  = 4'd1;
    localparam logic [3:0] CMD_MODE_SPI   = 4'd2;
    localparam logic [3:0] CMD_MODE_I2C   = 4'd3;
    localparam logic [3:0] CMD_SPI_MASTER = 4'd4;
    localparam logic [3:0] CMD_SPI_SLAVE  = 4'd5;
    localparam logic [3:0] CMD_CPOL       = 4'd6;
    localparam logic [3:0] CMD_CPHA       = 4'd7;
    localparam logic [3:0] CMD_I2C_MASTER = 4'd8;
    localparam logic [3:0] CMD_I2C_SLAVE  = 4'd9;
    localparam logic [3:0] CMD_UARTSPEED  = 4'd10;
    localparam logic [3:0] CMD_SPISPEED   = 4'd11;
    localparam logic [3:0] CMD_I2CSPEED   = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAIT_TX  = 3'd3,
        ST_WAIT_RSP = 3'd4,
        ST_FINISH   = 3'd5
    } state_e;

endpackage

// File: rtl/at_cmd_rom.sv
// Command string table: maps (id, arg, byte index) to the frame byte, a
// last-byte flag (the trailing LF) and whether the id/arg pair is legal.
module at_cmd_rom
    import at_cmd_host_pkg::*;
(
    input  logic [3:0] cmd_id_i,
    input  logic [2:0] cmd_arg_i,
    input  logic [3:0] idx_i,
    output logic [7:0] byte_o,
    output logic       last_o,
    output logic       arg_ok_o
);

    logic [103:0] body_s;
    logic [3:0]   len_s;
    logic         digit_s;
    logic [3:0]   pos_s;
    logic [4:0]   frame_len_s;

    // Body text is right-aligned in body_s; a digit, CR and LF follow it.
    always_comb begin
        body_s   = 104'd0;
        len_s    = 4'd0;
        digit_s  = 1'b0;
        arg_ok_o = 1'b1;
        case (cmd_id_i)
            CMD_AT:         begin body_s = {88'd0, "AT"};            len_s = 4'd2;  end
            CMD_MODE_UART:  begin body_s = {8'd0, "AT+MODE=UART"};   len_s = 4'd12; end
            CMD_MODE_SPI:   begin body_s = {16'd0, "AT+MODE=SPI"};   len_s = 4'd11; end
            CMD_MODE_I2C:   begin body_s = {16'd0, "AT+MODE=I2C"};   len_s = 4'd11; end
            CMD_SPI_MASTER: begin body_s = "AT+SPI=MASTER";          len_s = 4'd13; end
            CMD_SPI_SLAVE:  begin body_s = {8'd0, "AT+SPI=SLAVE"};   len_s = 4'd12; end
            CMD_CPOL: begin
                body_s = {40'd0, "AT+CPOL="}; len_s = 4'd8; digit_s = 1'b1;
                arg_ok_o = (cmd_arg_i <= 3'd1);
            end
            CMD_CPHA: begin
                body_s = {40'd0, "AT+CPHA="}; len_s = 4'd8; digit_s = 1'b1;
                arg_ok_o = (cmd_arg_i <= 3'd1);
            end
            CMD_I2C_MASTER: begin body_s = "AT+I2C=MASTER";          len_s = 4'd13; end
            CMD_I2C_SLAVE:  begin body_s = {8'd0, "AT+I2C=SLAVE"};   len_s = 4'd12; end
            CMD_UARTSPEED: begin
                body_s = "AT+UARTSPEED="; len_s = 4'd13; digit_s = 1'b1;
                arg_ok_o = (cmd_arg_i >= 3'd1) && (cmd_arg_i <= 3'd5);
            end
            CMD_SPISPEED: begin
                body_s = {8'd0, "AT+SPISPEED="}; len_s = 4'd12; digit_s = 1'b1;
                arg_ok_o = (cmd_arg_i >= 3'd1) && (cmd_arg_i <= 3'd5);
            end
            CMD_I2CSPEED: begin
                body_s = {8'd0, "AT+I2CSPEED="}; len_s = 4'd12; digit_s = 1'b1;
                arg_ok_o = (cmd_arg_i >= 3'd1) && (cmd_arg_i <= 3'd5);
            end
            default: arg_ok_o = 1'b0;
        endcase
    end

    // Byte select across body, optional digit, CR and LF.
    always_comb begin
        pos_s       = len_s - 4'd1 - idx_i;
        frame_len_s = {1'b0, len_s} + {4'd0, digit_s} + 5'd2;
        last_o      = ({1'b0, idx_i} == (frame_len_s - 5'd1));
        if (idx_i < len_s) begin
            byte_o = body_s[{pos_s, 3'b000} +: 8];
        end else if (digit_s && (idx_i == len_s)) begin
            byte_o = 8'h30 + {5'd0, cmd_arg_i};
        end else if (idx_i == (len_s + {3'd0, digit_s})) begin
            byte_o = CR;
        end else begin
            byte_o = LF;
        end
    end

endmodule

// File: rtl/at_cmd_host.sv
// AT-command initiator: sends the selected command frame through an external
// UART transmitter and classifies the reply as OK / ERROR / TIMEOUT.
module at_cmd_host
    import at_cmd_host_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter int          MAX_RSP_BYTES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_id,
    input  logic [2:0] cmd_arg,
    output logic       cmd_ready,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       done,
    output logic       rsp_ok,
    output logic       rsp_err,
    output logic       rsp_timeout
);

    localparam int TAIL_W = (MAX_RSP_BYTES - 1) * 8;
    // Synchroniser (2) plus the exit into FINISH (1) are folded into the load
    // so done lands exactly TIMEOUT_CYCLES after tx_busy falls.
    localparam logic [23:0] TIMER_LOAD = TIMEOUT_CYCLES - 24'd3;

    state_e            state_q, state_d;
    logic [3:0]        id_q, id_d;
    logic [2:0]        arg_q, arg_d;
    logic [3:0]        idx_q, idx_d;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic [23:0]       timer_q, timer_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_start_q, tx_start_d;
    logic              done_q, done_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              to_q, to_d;
    logic              ready_q, ready_d;
    logic              busy_s1_q, busy_s2_q;

    logic [7:0] rom_byte_s;
    logic       rom_last_s;
    logic       arg_ok_s;
    logic       busy_fall_s;
    logic       rx_lf_s;

    at_cmd_rom u_rom (
        .cmd_id_i  (id_q),
        .cmd_arg_i (arg_q),
        .idx_i     (idx_q),
        .byte_o    (rom_byte_s),
        .last_o    (rom_last_s),
        .arg_ok_o  (arg_ok_s)
    );

    assign busy_fall_s = busy_s2_q & ~busy_s1_q;
    assign rx_lf_s     = rx_valid & (rx_byte == LF);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        arg_d      = arg_q;
        idx_d      = idx_q;
        tail_d     = tail_q;
        timer_d    = timer_q;
        tx_byte_d  = tx_byte_q;
        tx_start_d = 1'b0;
        ok_d       = ok_q;
        err_d      = err_q;
        to_d       = to_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    id_d    = cmd_id;
                    arg_d   = cmd_arg;
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!arg_ok_s) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = 4'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_byte_d  = rom_byte_s;
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT_TX;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT_TX: begin
                if (busy_fall_s) begin
                    idx_d = idx_q + 4'd1;
                    if (rom_last_s) begin
                        tail_d  = '0;
                        timer_d = TIMER_LOAD;
                        state_d = ST_WAIT_RSP;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            ST_WAIT_RSP: begin
                if (rx_valid) begin
                    tail_d = {tail_q[TAIL_W-9:0], rx_byte};
                end else begin
                    tail_d = tail_q;
                end
                // An LF arriving on the expiry cycle still gets evaluated.
                if (rx_lf_s) begin
                    if (tail_d[OK_LEN*8-1:0] == OK_RESPONSE) begin
                        ok_d = 1'b1;
                    end else if (tail_d == ERROR_RESPONSE) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_FINISH;
                end else if (timer_q == 24'd0) begin
                    to_d    = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    timer_d = timer_q - 24'd1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        done_d  = (state_d == ST_FINISH);
        ready_d = (state_d == ST_IDLE);
    end

    // State, datapath and output registers; tx_busy is double-flopped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            id_q       <= 4'd0;
            arg_q      <= 3'd0;
            idx_q      <= 4'd0;
            tail_q     <= '0;
            timer_q    <= 24'd0;
            tx_byte_q  <= 8'd0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
            ready_q    <= 1'b1;
            busy_s1_q  <= 1'b0;
            busy_s2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            arg_q      <= arg_d;
            idx_q      <= idx_d;
            tail_q     <= tail_d;
            timer_q    <= timer_d;
            tx_byte_q  <= tx_byte_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            to_q       <= to_d;
            ready_q    <= ready_d;
            busy_s1_q  <= tx_busy;
            busy_s2_q  <= busy_s1_q;
        end
    end

    assign cmd_ready   = ready_q;
    assign tx_byte     = tx_byte_q;
    assign tx_start    = tx_start_q;
    assign done        = done_q;
    assign rsp_ok      = ok_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;

endmodule

// File: tb/tb_at_cmd_host.sv
// Scoreboard bench for at_cmd_host with a behavioural UART transmitter model.
module tb_at_cmd_host;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_id = 4'd0;
    logic [2:0] cmd_arg = 3'd0;
    logic       cmd_ready;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       rx_valid = 1'b0;
    logic       done, rsp_ok, rsp_err, rsp_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cap_cyc = 0;
    int fall_cyc = -1;
    int start_cnt = 0;
    int b2b_cnt = 0;
    int exp_starts = 0;
    logic prev_start = 1'b0;

    logic [7:0] exp_tx_q[$];
    logic [7:0] got_tx_q[$];
    int         exp_res_q[$];

    always #5 clk = ~clk;

    at_cmd_host #(.TIMEOUT_CYCLES(24'd100), .MAX_RSP_BYTES(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_id(cmd_id),
        .cmd_arg(cmd_arg), .cmd_ready(cmd_ready), .tx_byte(tx_byte),
        .tx_start(tx_start), .tx_busy(tx_busy), .rx_byte(rx_byte),
        .rx_valid(rx_valid), .done(done), .rsp_ok(rsp_ok), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout)
    );

    // Cycle counter and tx_start pulse monitor.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start === 1'b1) start_cnt <= start_cnt + 1;
        if (tx_start === 1'b1 && prev_start) b2b_cnt <= b2b_cnt + 1;
        prev_start <= (tx_start === 1'b1);
    end

    // UART transmitter model: busy for a few cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                got_tx_q.push_back(tx_byte);
                cap_cyc = cyc;
                @(posedge clk); #1 tx_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 tx_busy = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    function automatic void push_frame(input logic [3:0] id, input logic [2:0] arg);
        string base;
        bit    dig;
        dig = 1'b0;
        case (id)
            4'd0:  base = "AT";
            4'd1:  base = "AT+MODE=UART";
            4'd2:  base = "AT+MODE=SPI";
            4'd3:  base = "AT+MODE=I2C";
            4'd4:  base = "AT+SPI=MASTER";
            4'd5:  base = "AT+SPI=SLAVE";
            4'd6:  begin base = "AT+CPOL="; dig = 1'b1; end
            4'd7:  begin base = "AT+CPHA="; dig = 1'b1; end
            4'd8:  base = "AT+I2C=MASTER";
            4'd9:  base = "AT+I2C=SLAVE";
            4'd10: begin base = "AT+UARTSPEED="; dig = 1'b1; end
            4'd11: begin base = "AT+SPISPEED="; dig = 1'b1; end
            4'd12: begin base = "AT+I2CSPEED="; dig = 1'b1; end
            default: base = "";
        endcase
        for (int i = 0; i < base.len(); i++) exp_tx_q.push_back(base[i]);
        if (dig) exp_tx_q.push_back(8'h30 + {5'd0, arg});
        exp_tx_q.push_back(8'h0D);
        exp_tx_q.push_back(8'h0A);
        exp_starts = exp_starts + base.len() + int'(dig) + 2;
    endfunction

    task automatic drive_cmd(input logic [3:0] id, input logic [2:0] arg);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_id = id; cmd_arg = arg;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_rx(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1; rx_byte = s[i];
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_tx_done(input int n, input string name);
        int k;
        k = 0;
        while (!(got_tx_q.size() >= n && fall_cyc > cap_cyc) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 3000) begin
            checks++; errors++;
            $display("FAIL %s tx_wait: got %0d bytes, required %0d", name, got_tx_q.size(), n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_tx(input string name);
        logic [7:0] e, g;
        while (exp_tx_q.size() > 0) begin
            e = exp_tx_q.pop_front();
            checks++;
            if (got_tx_q.size() == 0) begin
                errors++;
                $display("FAIL %s tx_byte: got none, required %h", name, e);
            end else begin
                g = got_tx_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL %s tx_byte: got %h, required %h", name, g, e);
                end
            end
        end
        checks++;
        if (got_tx_q.size() != 0) begin
            errors++;
            $display("FAIL %s tx_extra: got %0d extra bytes, required 0", name, got_tx_q.size());
            got_tx_q.delete();
        end
    endtask

    task automatic wait_done(input string name, output int done_cyc);
        int k, r;
        logic [2:0] exp_f;
        k = 0;
        while (done !== 1'b1 && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        done_cyc = cyc;
        r = exp_res_q.pop_front();
        exp_f = (r == 0) ? 3'b100 : ((r == 1) ? 3'b010 : 3'b001);
        checks++;
        if (k >= 400) begin
            errors++;
            $display("FAIL %s done_wait: got no done, required done", name);
        end else if ({rsp_ok, rsp_err, rsp_timeout} !== exp_f) begin
            errors++;
            $display("FAIL %s result: got ok/err/to=%b, required %b", name,
                     {rsp_ok, rsp_err, rsp_timeout}, exp_f);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, cmd_ready, rsp_ok, rsp_err, rsp_timeout} !== {2'b01, exp_f}) begin
            errors++;
            $display("FAIL %s after_done: got done/ready/flags=%b, required %b", name,
                     {done, cmd_ready, rsp_ok, rsp_err, rsp_timeout}, {2'b01, exp_f});
        end
    endtask

    task automatic run_cmd(input logic [3:0] id, input logic [2:0] arg, input string reply,
                           input int res, input string name);
        int dc;
        push_frame(id, arg);
        exp_res_q.push_back(res);
        drive_cmd(id, arg);
        wait_tx_done(exp_tx_q.size(), name);
        check_tx(name);
        send_rx(reply);
        wait_done(name, dc);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, tx_byte, tx_start, done, rsp_ok, rsp_err, rsp_timeout} !== {1'b1, 8'h00, 5'b00000}) begin
            errors++;
            $display("FAIL reset_values: got %b, required %b",
                     {cmd_ready, tx_byte, tx_start, done, rsp_ok, rsp_err, rsp_timeout}, {1'b1, 8'h00, 5'b00000});
        end
        reset = 1'b1;
    endtask

    task automatic test_cmd_at();
        run_cmd(4'd0, 3'd0, "OK\r\n", 0, "at_ok");
    endtask

    task automatic test_uartspeed();
        run_cmd(4'd10, 3'd4, "ERROR\r\n", 1, "uartspeed_err");
    endtask

    task automatic test_reply_tail();
        run_cmd(4'd2, 3'd0, "xxOK\r\n", 0, "tail_ok");
        run_cmd(4'd9, 3'd0, "XYZ\r\n", 1, "unknown_reply");
        run_cmd(4'd12, 3'd5, "OK\r\n", 0, "i2cspeed_arg5");
        run_cmd(4'd7, 3'd0, "OK\r\n", 0, "cpha_arg0");
    endtask

    task automatic test_rx_ignored();
        int dc;
        push_frame(4'd0, 3'd0);
        exp_res_q.push_back(1);
        drive_cmd(4'd0, 3'd0);
        send_rx("OK\r\n");
        wait_tx_done(exp_tx_q.size(), "rx_during_send");
        check_tx("rx_during_send");
        send_rx("XYZ\r\n");
        wait_done("rx_during_send", dc);
    endtask

    task automatic test_bad_arg();
        logic [3:0] ids[5]  = '{4'd11, 4'd14, 4'd6, 4'd10, 4'd15};
        logic [2:0] args[5] = '{3'd0, 3'd0, 3'd2, 3'd6, 3'd3};
        int s0;
        for (int i = 0; i < 5; i++) begin
            s0 = start_cnt;
            drive_cmd(ids[i], args[i]);
            checks++;
            if ({done, cmd_ready} !== 2'b00) begin
                errors++;
                $display("FAIL bad_arg%0d cycle1: got done/ready=%b, required 00", i, {done, cmd_ready});
            end
            @(posedge clk); #1;
            checks++;
            if ({done, rsp_ok, rsp_err, rsp_timeout} !== 4'b1010) begin
                errors++;
                $display("FAIL bad_arg%0d cycle2: got done/ok/err/to=%b, required 1010", i,
                         {done, rsp_ok, rsp_err, rsp_timeout});
            end
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (start_cnt !== s0) begin
                errors++;
                $display("FAIL bad_arg%0d tx_starts: got %0d, required 0", i, start_cnt - s0);
            end
        end
    endtask

    task automatic test_timeout();
        int dc;
        push_frame(4'd6, 3'd1);
        exp_res_q.push_back(2);
        drive_cmd(4'd6, 3'd1);
        wait_tx_done(exp_tx_q.size(), "timeout");
        check_tx("timeout");
        wait_done("timeout", dc);
        checks++;
        if (dc - fall_cyc + 1 !== 101) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles, required 100", dc - fall_cyc);
        end
    endtask

    task automatic test_reset_mid();
        string pre;
        int k;
        pre = "AT+MO";
        exp_starts = exp_starts + 5;
        drive_cmd(4'd1, 3'd0);
        k = 0;
        while (got_tx_q.size() < 5 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, tx_byte, tx_start, done, rsp_ok, rsp_err, rsp_timeout} !== {1'b1, 8'h00, 5'b00000}) begin
            errors++;
            $display("FAIL reset_mid: got %b, required %b",
                     {cmd_ready, tx_byte, tx_start, done, rsp_ok, rsp_err, rsp_timeout}, {1'b1, 8'h00, 5'b00000});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 5; i++) exp_tx_q.push_back(pre[i]);
        wait_tx_done(5, "reset_mid");
        repeat (10) @(posedge clk);
        check_tx("reset_mid");
        run_cmd(4'd0, 3'd0, "OK\r\n", 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        checks++;
        if (b2b_cnt !== 0) begin
            errors++;
            $display("FAIL back_to_back: got %0d adjacent tx_start pulses, required 0", b2b_cnt);
        end
        checks++;
        if (start_cnt !== exp_starts) begin
            errors++;
            $display("FAIL start_count: got %0d, required %0d", start_cnt, exp_starts);
        end
    endtask

    initial begin
        test_reset();
        test_cmd_at();
        test_uartspeed();
        test_reply_tail();
        test_rx_ignored();
        test_bad_arg();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
